// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO pair.
// Define MULDIV_DIV_EN to build the restoring divider (DIV/DIVU); otherwise they are reserved.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_read,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod;

`ifdef MULDIV_DIV_EN
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic                 isdiv_q, isdiv_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH:0]       div_sh, div_tr;
`endif

    assign signed_op = ~op[0];
    assign rs_mag    = (signed_op & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag    = (signed_op & rt_val[WIDTH-1]) ? -rt_val : rt_val;
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{b_q[0]}}};
    assign prod      = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    // Remainder lives in acc[63:32]; dividend bits shift out of b while quotient bits shift in.
    assign div_sh = {acc_q[2*WIDTH-1:WIDTH], b_q[WIDTH-1]};
    assign div_tr = div_sh - {1'b0, a_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        isdiv_d = isdiv_q;
        dbz_d   = 1'b0;
        dvd_d   = dvd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            a_d     = rs_mag;
                            b_d     = rt_mag;
                            neg_d   = signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            acc_d   = '0;
                            cnt_d   = '0;
`ifdef MULDIV_DIV_EN
                            isdiv_d = 1'b0;
`endif
                            state_d = S_MUL;
                        end
`ifdef MULDIV_DIV_EN
                        3'b010, 3'b011: begin
                            a_d     = rt_mag;
                            b_d     = rs_mag;
                            neg_d   = signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            rneg_d  = signed_op & rs_val[WIDTH-1];
                            dz_d    = (rt_val == '0);
                            dvd_d   = rs_val;
                            isdiv_d = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
`endif
                        3'b100:  hi_d = rs_val;
                        3'b101:  lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                acc_d[2*WIDTH-1:WIDTH] = div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0];
                b_d   = {b_q[WIDTH-2:0], ~div_tr[WIDTH]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
`endif
            S_FIX: begin
                hi_d   = prod[2*WIDTH-1:WIDTH];
                lo_d   = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
                if (isdiv_q && dz_q) begin
                    hi_d  = dvd_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (isdiv_q) begin
                    lo_d = neg_q ? -b_q : b_q;
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            isdiv_q <= 1'b0;
            dbz_q   <= 1'b0;
            dvd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            isdiv_q <= isdiv_d;
            dbz_q   <= dbz_d;
            dvd_q   <= dvd_d;
`endif
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | hilo_read);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
`ifdef MULDIV_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: random and directed HI/LO ops vs. an arithmetic model.
// Follows MULDIV_DIV_EN the same way the design does.
module tb_hilo_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        hilo_read = 1'b0;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;

    logic [64:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_read(hilo_read),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Returns {div_by_zero, hi, lo} from the architectural definition of each op.
    function automatic logic [64:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] p;
        case (o)
            3'b000: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                return {1'b0, p};
            end
            3'b001: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 3'b010) begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                end else begin
                    x = longint'({32'b0, a});
                    y = longint'({32'b0, b});
                end
                q = x / y;
                r = x % y;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic bit is_long(input logic [2:0] o);
        return (o == 3'b000) || (o == 3'b001) || (DIV_EN && (o == 3'b010 || o == 3'b011));
    endfunction

    always @(negedge clk) begin
        if (done || div_by_zero) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {63'b0, done}, 64'd0);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("done_pulse", {63'b0, done}, 64'd1);
                chk("hi_result", {32'b0, hi}, {32'b0, e[63:32]});
                chk("lo_result", {32'b0, lo}, {32'b0, e[31:0]});
                chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e[64]});
            end
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] e;
        int n;
        if (is_long(o)) begin
            e = ref_op(o, a, b);
            exp_q.push_back(e);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end else if (o == 3'b100) begin
            m_hi = a;
        end else if (o == 3'b101) begin
            m_lo = a;
        end
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (is_long(o)) begin
            wait_idle(n);
            chk("busy_cycles", 64'(n), 64'd33);
        end else begin
            chk("no_busy", {63'b0, busy}, 64'd0);
            chk("hi_short", {32'b0, hi}, {32'b0, m_hi});
            chk("lo_short", {32'b0, lo}, {32'b0, m_lo});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [64:0] e;
        logic [31:0] old_hi;

        #12;
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(3'b001, 32'hFFFF_FFFF, 32'd2);
        do_op(3'b000, 32'hFFFF_FFFD, 32'd5);
        do_op(3'b010, 32'hFFFF_FFF9, 32'd2);
        do_op(3'b011, 32'd100, 32'd0);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'b000, 32'h8000_0000, 32'h8000_0000);
        do_op(3'b101, 32'h1234_5678, 32'd0);

        // MFHI and a re-presented MTHI held against an in-flight MULT
        e = ref_op(3'b000, 32'h0001_0003, 32'hFFFF_0007);
        exp_q.push_back(e);
        old_hi = m_hi;
        @(negedge clk);
        start = 1'b1; op = 3'b000; rs_val = 32'h0001_0003; rt_val = 32'hFFFF_0007;
        @(posedge clk);
        #1;
        op = 3'b100; rs_val = 32'hDEAD_BEEF; hilo_read = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            chk("stall_busy", {63'b0, stall}, 64'd1);
            chk("hi_held", {32'b0, hi}, {32'b0, old_hi});
            @(negedge clk);
        end
        chk("stall_cycles", 64'(n), 64'd33);
        chk("stall_idle", {63'b0, stall}, 64'd0);
        chk("hi_after_fix", {32'b0, hi}, {32'b0, e[63:32]});
        @(posedge clk);
        #1;
        start = 1'b0; hilo_read = 1'b0;
        m_hi = 32'hDEAD_BEEF;
        m_lo = e[31:0];
        chk("mthi_replay", {32'b0, hi}, {32'b0, m_hi});
        chk("mthi_no_busy", {63'b0, busy}, 64'd0);

        // Reset 10 cycles into a long operation
        @(negedge clk);
        start = 1'b1; op = DIV_EN ? 3'b010 : 3'b000;
        rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_hi", {32'b0, hi}, 64'd0);
        chk("midrst_lo", {32'b0, lo}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        do_op(3'b001, 32'd6, 32'd7);

        do_op(3'b110, 32'hAAAA_5555, 32'd3);
        do_op(3'b111, 32'h5555_AAAA, 32'd9);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 5));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = b & 32'h0000_00FF;
            do_op(o, a, b);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit for the MIPS pipeline, owning the architectural HI and LO registers. Sits beside the EX stage: it consumes the ID/EX operand values for MULT/MULTU/DIV/DIVU/MTHI/MTLO and feeds HI/LO to the Operand2 handler for MFHI/MFLO. A stall request goes to the hazard/forwarding unit while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset is asynchronous and active-low.
- `start` in 1: EX stage holds a HI/LO-class instruction this cycle.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `rs_val` in 32: forwarded rs value (multiplicand/dividend/MTxx source).
- `rt_val` in 32: forwarded rt value (multiplier/divisor).
- `hilo_read` in 1: ID holds MFHI/MFLO.
- `busy` out 1: operation in flight.
- `stall` out 1: `busy & (start | hilo_read)`, combinational.
- `done` out 1: one-cycle pulse when HI/LO are written by MUL/DIV.
- `div_by_zero` out 1: one-cycle pulse coincident with `done` for a DIV/DIVU with `rt_val`==0.
- `hi` out 32, `lo` out 32: architectural HI/LO.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with `start`, op=MULT/MULTU:
  - Capture operand magnitudes. Magnitudes are taken only for signed ops; |−2^31| is 0x8000_0000 unsigned.
  - Capture the result sign (XOR of operand MSBs for MULT).
  - Clear the 64-bit accumulator and the 5-bit counter, then go to MUL.
- IDLE with `start`, op=DIV/DIVU: same operand capture, then go to DIV. Quotient sign is the XOR of the MSBs; remainder sign follows the dividend.
- MUL: one shift-add step per cycle over the multiplier LSB. After 32 steps (counter wraps 31→0), go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After 32 steps, go to FIX.
- FIX:
  - Apply two's-complement negation per the captured signs.
  - Write HI/LO: MUL writes HI=product[63:32], LO=product[31:0]; DIV writes LO=quotient, HI=remainder.
  - Pulse `done`, return to IDLE.
- Divide by zero: FIX writes HI=captured `rs_val`, LO=32'hFFFF_FFFF, pulses `div_by_zero`. Signedness is ignored in this case.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0, no flag.
- MTHI/MTLO in IDLE: HI (or LO) ← `rs_val` at that edge. Single cycle, no `busy`, no `done`.
- `start` while busy: ignored. Upstream is held by `stall` and re-presents the instruction.
- Reserved op: no state change.
- HI/LO keep their old values until FIX. MFHI during busy is stalled, never served a partial result.

## Timing
- Reset (async assert): state=IDLE; `hi`=`lo`=0; `busy`=`done`=`div_by_zero`=0; counter and accumulators cleared.
- Reset mid-operation: the in-flight result is discarded.
- `start` sampled at edge E0.
- `busy` is high from after E0 to after E33 (33 cycles): steps at E1..E32, FIX at E33.
- `hi`/`lo` update at E33; `done` is high for the cycle after E33.
- `start` at E33 is not accepted (`busy` still high); the earliest next accept is E34.
- MTHI/MTLO latency: 1 edge. The new value is visible the cycle after E0.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU supported as above.
- `MULDIV_DIV_EN` undefined:
  - The DIV state and divider datapath are not compiled.
  - op=010/011 is treated as reserved (no effect, no `busy`).
  - `div_by_zero` is tied to 0.

## Test plan
- MULTU rs=0xFFFF_FFFF, rt=2 → `busy` 33 cycles, then HI=0x0000_0001, LO=0xFFFF_FFFE, `done` 1 cycle.
- MULT rs=−3 (0xFFFF_FFFD), rt=5 → HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
- DIV rs=−7, rt=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU rs=100, rt=0 → HI=0x64, LO=0xFFFF_FFFF, `div_by_zero` with `done`.
- Hold `hilo_read`=1 and `start` with op=MTHI during a MULT → `stall`=1 throughout `busy`, HI unchanged until FIX. MTHI re-presented at E34 → HI=`rs_val` next cycle.
- Assert `reset` low at cycle 10 of a DIV → HI=LO=0, `busy`=0 immediately. A following MULTU 6×7 after release → LO=42, HI=0.
- Build without `MULDIV_DIV_EN`, issue op=010 → `busy` stays 0, HI/LO unchanged, `done` never pulses.
